// File: rtl/bus_source_encoder.sv
// Registered bus-source select encoder with contention detection and counting.
// Optional BUS_ENC_HOLD_EN: hold the last valid select code while the bus is idle.
module bus_source_encoder #(
  parameter int unsigned NUM_SRC   = 24,
  parameter int unsigned SEL_W     = 5,
  parameter int unsigned IDLE_CODE = 31,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [NUM_SRC-1:0] src_out,
  input  logic               clr_err,
  output logic [SEL_W-1:0]   encOut,
  output logic               bus_valid,
  output logic               contention,
  output logic               err_sticky,
  output logic [CNT_W-1:0]   contention_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic             any_c;
  logic             multi_c;
  logic [SEL_W-1:0] low_idx_c;
  logic [SEL_W-1:0] enc_nxt_c;

  // Lowest set strobe wins when several drivers are requested.
  always_comb begin
    low_idx_c = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (src_out[i]) low_idx_c = SEL_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something behind only when two or more are set.
  assign any_c   = |src_out;
  assign multi_c = |(src_out & (src_out - NUM_SRC'(1)));

`ifdef BUS_ENC_HOLD_EN
  assign enc_nxt_c = any_c ? low_idx_c : encOut;
`else
  assign enc_nxt_c = any_c ? low_idx_c : SEL_W'(IDLE_CODE);
`endif

  // Bus ownership state register.
  always_ff @(posedge clock) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // Ownership transitions.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_c)  state_nxt = OWNED;
      OWNED:   if (!any_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ownership is exposed directly as the valid flag.
  always_comb begin
    bus_valid = 1'b0;
    if (state == OWNED) bus_valid = 1'b1;
  end

  // Registered select and per-cycle contention flag.
  always_ff @(posedge clock) begin
    if (clear) begin
      encOut     <= SEL_W'(IDLE_CODE);
      contention <= 1'b0;
    end else begin
      encOut     <= enc_nxt_c;
      contention <= multi_c;
    end
  end

  // Sticky error and saturating counter; clr_err beats a same-cycle contention.
  always_ff @(posedge clock) begin
    if (clear) begin
      err_sticky     <= 1'b0;
      contention_cnt <= '0;
    end else if (clr_err) begin
      err_sticky     <= 1'b0;
      contention_cnt <= '0;
    end else if (multi_c) begin
      err_sticky <= 1'b1;
      if (contention_cnt != '1) contention_cnt <= contention_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bus_source_encoder.sv
// Randomized self-checking bench for bus_source_encoder against a behavioural model.
module tb_bus_source_encoder;

  localparam int unsigned NUM_SRC = 24;
  localparam int unsigned SEL_W   = 5;
  localparam int unsigned CNT_W   = 8;
  localparam int          IDLE    = 31;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic               clock = 1'b0;
  logic               clear;
  logic [NUM_SRC-1:0] src_out;
  logic               clr_err;
  logic [SEL_W-1:0]   encOut;
  logic               bus_valid;
  logic               contention;
  logic               err_sticky;
  logic [CNT_W-1:0]   contention_cnt;

  int tests = 0;
  int fails = 0;

  int m_enc   = IDLE;
  int m_valid = 0;
  int m_cont  = 0;
  int m_err   = 0;
  int m_cnt   = 0;

  always #5 clock = ~clock;

  bus_source_encoder dut (
    .clock          (clock),
    .clear          (clear),
    .src_out        (src_out),
    .clr_err        (clr_err),
    .encOut         (encOut),
    .bus_valid      (bus_valid),
    .contention     (contention),
    .err_sticky     (err_sticky),
    .contention_cnt (contention_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: what the outputs should show after an edge with these inputs.
  function automatic void model_update(input logic clr, input logic [NUM_SRC-1:0] src,
                                       input logic ce);
    int n;
    int low;
    n   = $countones(src);
    low = -1;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (src[i] && low < 0) low = i;
    end
    if (clr) begin
      m_enc = IDLE; m_valid = 0; m_cont = 0; m_err = 0; m_cnt = 0;
      return;
    end
    if (n == 0) begin
      m_valid = 0;
`ifndef BUS_ENC_HOLD_EN
      m_enc = IDLE;
`endif
    end else begin
      m_valid = 1;
      m_enc   = low;
    end
    m_cont = (n >= 2) ? 1 : 0;
    if (ce) begin
      m_err = 0;
      m_cnt = 0;
    end else if (n >= 2) begin
      m_err = 1;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  endfunction

  task automatic cycle(input logic clr, input logic [NUM_SRC-1:0] src, input logic ce);
    @(negedge clock);
    clear   = clr;
    src_out = src;
    clr_err = ce;
    @(posedge clock);
    model_update(clr, src, ce);
    #1;
    check("encOut",         int'(encOut),         m_enc);
    check("bus_valid",      int'(bus_valid),      m_valid);
    check("contention",     int'(contention),     m_cont);
    check("err_sticky",     int'(err_sticky),     m_err);
    check("contention_cnt", int'(contention_cnt), m_cnt);
  endtask

  function automatic logic [NUM_SRC-1:0] bit_of(input int k);
    logic [NUM_SRC-1:0] one;
    one = NUM_SRC'(1);
    return one << k;
  endfunction

  initial begin
    logic [NUM_SRC-1:0] s;
    logic               c;
    logic               e;
    int                 a;
    int                 b;

    clear   = 1'b1;
    src_out = '1;
    clr_err = 1'b0;

    cycle(1'b1, 24'hFFFFFF, 1'b0);
    cycle(1'b1, 24'hFFFFFF, 1'b0);
    check("reset_enc_const", int'(encOut), 31);

    cycle(1'b0, bit_of(0),  1'b0);
    cycle(1'b0, bit_of(15), 1'b0);
    cycle(1'b0, bit_of(20), 1'b0);
    cycle(1'b0, bit_of(23), 1'b0);
    cycle(1'b0, '0,         1'b0);

    cycle(1'b0, bit_of(5) | bit_of(21), 1'b0);
    check("contention_enc_const", int'(encOut), 5);
    cycle(1'b0, bit_of(21), 1'b0);

    for (int i = 0; i < 300; i++) cycle(1'b0, 24'h000003 << (i % 20), 1'b0);
    check("saturated_cnt_const", int'(contention_cnt), 255);
    cycle(1'b0, 24'h800001, 1'b0);
    cycle(1'b0, bit_of(7), 1'b1);

    cycle(1'b0, bit_of(9) | bit_of(12), 1'b0);
    cycle(1'b0, bit_of(3) | bit_of(22), 1'b1);

    cycle(1'b0, bit_of(20), 1'b0);
    cycle(1'b1, bit_of(20), 1'b0);
    cycle(1'b0, '0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: s = '0;
        1: s = bit_of(int'($urandom_range(0, NUM_SRC - 1)));
        2: begin
          a = int'($urandom_range(0, NUM_SRC - 1));
          b = int'($urandom_range(0, NUM_SRC - 1));
          s = bit_of(a) | bit_of(b);
        end
        default: s = NUM_SRC'($urandom);
      endcase
      c = ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 15) == 0);
      cycle(c, s, e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
